// File: rtl/bip_pkg.sv
// Shared encodings for the BIP control unit: opcodes, accumulator-mux selects and FSM states.
package bip_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_RAM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op_sub;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode -> datapath/data-memory strobes; everything is 0 unless exec_en.
// Latency: 0 cycles; no backpressure.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                    exec_en,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [1:0]              sel_a,
  output logic                    sel_b,
  output logic                    op_sub,
  output logic                    wr_acc,
  output logic                    wr_ram,
  output logic                    rd_ram,
  output logic                    illegal
);

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    if (exec_en) begin
      case (opcode)
        OPCODE_WIDTH'(OP_HLT): ctrl = '0;
        OPCODE_WIDTH'(OP_STO): ctrl.wr_ram = 1'b1;
        OPCODE_WIDTH'(OP_LD): begin
          ctrl.rd_ram = 1'b1;
          ctrl.wr_acc = 1'b1;
          ctrl.sel_a  = SELA_RAM;
        end
        OPCODE_WIDTH'(OP_LDI): begin
          ctrl.wr_acc = 1'b1;
          ctrl.sel_a  = SELA_IMM;
        end
        OPCODE_WIDTH'(OP_ADD): begin
          ctrl.rd_ram = 1'b1;
          ctrl.wr_acc = 1'b1;
          ctrl.sel_a  = SELA_ALU;
        end
        OPCODE_WIDTH'(OP_ADDI): begin
          ctrl.wr_acc = 1'b1;
          ctrl.sel_a  = SELA_ALU;
          ctrl.sel_b  = 1'b1;
        end
        OPCODE_WIDTH'(OP_SUB): begin
          ctrl.rd_ram = 1'b1;
          ctrl.wr_acc = 1'b1;
          ctrl.sel_a  = SELA_ALU;
          ctrl.op_sub = 1'b1;
        end
        OPCODE_WIDTH'(OP_SUBI): begin
          ctrl.wr_acc = 1'b1;
          ctrl.sel_a  = SELA_ALU;
          ctrl.sel_b  = 1'b1;
          ctrl.op_sub = 1'b1;
        end
        // Undefined opcodes execute as NOP but are flagged.
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

  assign sel_a   = ctrl.sel_a;
  assign sel_b   = ctrl.sel_b;
  assign op_sub  = ctrl.op_sub;
  assign wr_acc  = ctrl.wr_acc;
  assign wr_ram  = ctrl.wr_ram;
  assign rd_ram  = ctrl.rd_ram;
  assign illegal = ctrl.illegal;

endmodule

// File: rtl/bip_control.sv
// BIP control unit: PC, FETCH/EXEC sequencing, start/halt, wrap control and instruction counter.
// Latency: 2 cycles per instruction, first strobe 2 cycles after start; no backpressure.
module bip_control
  import bip_pkg::*;
#(
  parameter int PC_WIDTH      = 11,
  parameter int OPCODE_WIDTH  = 5,
  parameter int OPERAND_WIDTH = 11,
  parameter int CNT_WIDTH     = 16,
  parameter int HALT_ON_WRAP  = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]                   address,
  output logic [OPERAND_WIDTH-1:0]              operand,
  output logic [1:0]                            sel_a,
  output logic                                  sel_b,
  output logic                                  op_sub,
  output logic                                  wr_acc,
  output logic                                  wr_ram,
  output logic                                  rd_ram,
  output logic                                  busy,
  output logic                                  halted,
  output logic                                  illegal,
  output logic [CNT_WIDTH-1:0]                  instr_count
);

  localparam int INSTR_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                  exec_en;

  assign opcode  = instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign exec_en = (state_q == ST_EXEC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        // A restart from HALT keeps the instruction count.
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (!(&cnt_q)) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (opcode == OPCODE_WIDTH'(OP_HLT)) begin
          state_d = ST_HALT;
        end else if (&pc_q) begin
          if (HALT_ON_WRAP != 0) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = '0;
            state_d = ST_FETCH;
          end
        end else begin
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  bip_decoder #(
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_decoder (
    .exec_en (exec_en),
    .opcode  (opcode),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .op_sub  (op_sub),
    .wr_acc  (wr_acc),
    .wr_ram  (wr_ram),
    .rd_ram  (rd_ram),
    .illegal (illegal)
  );

  assign address     = pc_q;
  assign operand     = exec_en ? instr[OPERAND_WIDTH-1:0] : '0;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign halted      = (state_q == ST_HALT);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: one default instance plus two 3-bit-PC instances for wrap and
// counter saturation; expected EXEC records are queued at stimulus time and popped per EXEC.
module tb_bip_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  int   dut_sel;
  int   n_checks = 0;
  int   n_err    = 0;
  int   exp_cnt;

  // main instance: default parameters
  logic [15:0] m_instr;
  logic [10:0] m_addr, m_opnd;
  logic [1:0]  m_sela;
  logic        m_selb, m_sub, m_wacc, m_wram, m_rram, m_busy, m_halt, m_ill;
  logic [15:0] m_cnt;
  // w1: 3-bit PC, halts on wrap
  logic [15:0] w1_instr;
  logic [2:0]  w1_addr;
  logic [10:0] w1_opnd;
  logic [1:0]  w1_sela;
  logic        w1_selb, w1_sub, w1_wacc, w1_wram, w1_rram, w1_busy, w1_halt, w1_ill;
  logic [15:0] w1_cnt;
  // w0: 3-bit PC, wraps, 3-bit counter
  logic [15:0] w0_instr;
  logic [2:0]  w0_addr;
  logic [10:0] w0_opnd;
  logic [1:0]  w0_sela;
  logic        w0_selb, w0_sub, w0_wacc, w0_wram, w0_rram, w0_busy, w0_halt, w0_ill;
  logic [2:0]  w0_cnt;

  bip_control u_main (
    .clk(clk), .reset(reset), .start(start && dut_sel == 0), .instr(m_instr),
    .address(m_addr), .operand(m_opnd), .sel_a(m_sela), .sel_b(m_selb), .op_sub(m_sub),
    .wr_acc(m_wacc), .wr_ram(m_wram), .rd_ram(m_rram), .busy(m_busy), .halted(m_halt),
    .illegal(m_ill), .instr_count(m_cnt)
  );

  bip_control #(.PC_WIDTH(3), .HALT_ON_WRAP(1)) u_w1 (
    .clk(clk), .reset(reset), .start(start && dut_sel == 1), .instr(w1_instr),
    .address(w1_addr), .operand(w1_opnd), .sel_a(w1_sela), .sel_b(w1_selb), .op_sub(w1_sub),
    .wr_acc(w1_wacc), .wr_ram(w1_wram), .rd_ram(w1_rram), .busy(w1_busy), .halted(w1_halt),
    .illegal(w1_ill), .instr_count(w1_cnt)
  );

  bip_control #(.PC_WIDTH(3), .CNT_WIDTH(3), .HALT_ON_WRAP(0)) u_w0 (
    .clk(clk), .reset(reset), .start(start && dut_sel == 2), .instr(w0_instr),
    .address(w0_addr), .operand(w0_opnd), .sel_a(w0_sela), .sel_b(w0_selb), .op_sub(w0_sub),
    .wr_acc(w0_wacc), .wr_ram(w0_wram), .rd_ram(w0_rram), .busy(w0_busy), .halted(w0_halt),
    .illegal(w0_ill), .instr_count(w0_cnt)
  );

  // Synchronous-read program memories
  logic [15:0] mem_m  [0:2047];
  logic [15:0] mem_w1 [0:7];
  logic [15:0] mem_w0 [0:7];
  always @(posedge clk) begin
    m_instr  <= mem_m[m_addr];
    w1_instr <= mem_w1[w1_addr];
    w0_instr <= mem_w0[w0_addr];
  end

  // Observed outputs of the instance under test
  logic [7:0]  o_ctrl;
  logic [10:0] o_addr, o_opnd;
  logic [15:0] o_cnt;
  logic        o_busy, o_halt;
  always_comb begin
    o_ctrl = {m_sela, m_selb, m_sub, m_wacc, m_wram, m_rram, m_ill};
    o_addr = m_addr;
    o_opnd = m_opnd;
    o_cnt  = m_cnt;
    o_busy = m_busy;
    o_halt = m_halt;
    if (dut_sel == 1) begin
      o_ctrl = {w1_sela, w1_selb, w1_sub, w1_wacc, w1_wram, w1_rram, w1_ill};
      o_addr = {8'd0, w1_addr};
      o_opnd = w1_opnd;
      o_cnt  = w1_cnt;
      o_busy = w1_busy;
      o_halt = w1_halt;
    end else if (dut_sel == 2) begin
      o_ctrl = {w0_sela, w0_selb, w0_sub, w0_wacc, w0_wram, w0_rram, w0_ill};
      o_addr = {8'd0, w0_addr};
      o_opnd = w0_opnd;
      o_cnt  = {13'd0, w0_cnt};
      o_busy = w0_busy;
      o_halt = w0_halt;
    end
  end

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [10:0] opnd;
    logic [10:0] addr;
  } exp_t;
  exp_t sb[$];

  // {sel_a[1:0], sel_b, op_sub, wr_acc, wr_ram, rd_ram, illegal}
  function automatic logic [7:0] ref_ctrl(input logic [4:0] op);
    case (op)
      5'b00000: return {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      5'b00001: return {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      5'b00010: return {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      5'b00011: return {2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      5'b00100: return {2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      5'b00101: return {2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      5'b00110: return {2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      5'b00111: return {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      default:  return {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    endcase
  endfunction

  function automatic logic [15:0] ins(input logic [4:0] op, input int opnd);
    return {op, 11'(opnd)};
  endfunction

  task automatic push(input logic [15:0] i, input int addr);
    sb.push_back({ref_ctrl(i[15:11]), i[10:0], 11'(addr)});
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called mid-FETCH; checks FETCH then the EXEC that follows, n times.
  task automatic run(input int n);
    exp_t e;
    int   cmax;
    cmax = (dut_sel == 2) ? 7 : 65535;
    for (int k = 0; k < n; k++) begin
      check("fetch_busy", 32'(o_busy), 32'd1);
      check("fetch_strobes", 32'(o_ctrl), 32'd0);
      check("fetch_operand", 32'(o_opnd), 32'd0);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $error("FAIL sb_empty: observed exec with empty queue, expected none");
      end else begin
        e = sb.pop_front();
        check("exec_strobes", 32'(o_ctrl), 32'(e.ctrl));
        check("exec_operand", 32'(o_opnd), 32'(e.opnd));
        check("exec_address", 32'(o_addr), 32'(e.addr));
      end
      check("exec_count", 32'(o_cnt), 32'(exp_cnt));
      check("exec_busy", 32'(o_busy), 32'd1);
      exp_cnt = (exp_cnt == cmax) ? cmax : exp_cnt + 1;
      @(negedge clk);
    end
  endtask

  task automatic check_halt(input string tag, input int addr, input int cnt);
    check({tag, "_halted"}, 32'(o_halt), 32'd1);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_addr"}, 32'(o_addr), 32'(addr));
    check({tag, "_count"}, 32'(o_cnt), 32'(cnt));
    check({tag, "_strobes"}, 32'(o_ctrl), 32'd0);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    dut_sel = 0;
    exp_cnt = 0;
    mem_m[0] = ins(5'b00100, 9);
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(o_addr), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_halted", 32'(o_halt), 32'd0);
    check("rst_count", 32'(o_cnt), 32'd0);
    check("rst_strobes", 32'(o_ctrl), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of an ADD's EXEC cycle
    push(mem_m[0], 0);
    go();
    check("add_fetch_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    check("add_wr_acc", 32'(m_wacc), 32'd1);
    check("add_rd_ram", 32'(m_rram), 32'd1);
    void'(sb.pop_front());
    reset = 1'b0;
    #1;
    check("abort_wr_acc", 32'(m_wacc), 32'd0);
    check("abort_strobes", 32'(o_ctrl), 32'd0);
    check("abort_addr", 32'(o_addr), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_halted", 32'(o_halt), 32'd0);
    @(negedge clk);
    check("abort_idle_busy", 32'(o_busy), 32'd0);
    check("abort_operand", 32'(o_opnd), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // LDI 5; ADDI 3; STO 7; HLT
    mem_m[0] = ins(5'b00011, 5);
    mem_m[1] = ins(5'b00101, 3);
    mem_m[2] = ins(5'b00001, 7);
    mem_m[3] = ins(5'b00000, 0);
    for (int a = 0; a < 4; a++) push(mem_m[a], a);
    exp_cnt = 0;
    go();
    run(4);
    check_halt("prog", 3, 4);
    @(negedge clk);
    check("prog_halt_hold", 32'(o_halt), 32'd1);

    // Restart from HALT with start held high across the first instruction
    for (int a = 0; a < 4; a++) push(mem_m[a], a);
    start = 1'b1;
    @(negedge clk);
    check("restart_addr", 32'(o_addr), 32'd0);
    check("restart_count", 32'(o_cnt), 32'd4);
    run(1);
    start = 1'b0;
    run(3);
    check_halt("restart", 3, 8);

    // Illegal opcode then HLT, from a fresh reset
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mem_m[0] = ins(5'b11111, 11'h5a);
    mem_m[1] = ins(5'b00000, 0);
    push(mem_m[0], 0);
    push(mem_m[1], 1);
    exp_cnt = 0;
    @(negedge clk);
    go();
    run(2);
    check_halt("illegal", 1, 2);

    // Wrap with halt: LDI at every address of a 3-bit PC
    dut_sel = 1;
    exp_cnt = 0;
    for (int a = 0; a < 8; a++) begin
      mem_w1[a] = ins(5'b00011, a * 3 + 1);
      push(mem_w1[a], a);
    end
    @(negedge clk);
    go();
    run(8);
    check_halt("wrap_halt", 7, 8);

    // Wrap without halt, 3-bit counter saturates over 10 instructions
    dut_sel = 2;
    exp_cnt = 0;
    for (int a = 0; a < 8; a++) mem_w0[a] = ins(5'b00011, a + 100);
    for (int k = 0; k < 10; k++) push(mem_w0[k % 8], k % 8);
    @(negedge clk);
    go();
    run(10);
    check("wrap_run_busy", 32'(o_busy), 32'd1);
    check("wrap_run_halted", 32'(o_halt), 32'd0);
    check("wrap_run_addr", 32'(o_addr), 32'd2);
    check("sat_count", 32'(o_cnt), 32'd7);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
